uart_fifo_ctrl: RTL and testbench

Memory-mapped UART controller with parametrised RX/TX FIFOs, the successor to the single-byte serial controller. Sits between the device controller (one-cycle register accesses from the CPU) and the async receiver/transmitter pair on clkMain. It adds buffering of configurable depth, sticky overflow flags, fill-level status and maskable level/empty interrupts feeding the COM interrupt line.

---
 rtl/uart_fifo_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_fifo_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - register map, status bit positions and TX launcher states
package uart_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_TX_NFULL  = 0;
  localparam int ST_RX_NEMPTY = 1;
  localparam int ST_RX_OVF    = 2;
  localparam int ST_TX_EMPTY  = 3;
  localparam int ST_TX_DROP   = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_GUARD = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with a registered count
// A pop on a full FIFO frees the slot for a push in the same cycle.
module sync_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clkMain,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int PW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {PW{1'b0}}};

  logic [W-1:0]  mem [0:(1 << DEPTH_LOG2) - 1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clkMain) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clkMain) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - memory-mapped UART controller with RX/TX FIFOs
// Register accesses act once per rising edge of enable_i; holding it high is a no-op.
module uart_fifo_ctrl #(
  parameter int DATA_W       = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int RX_INT_LEVEL = 1
) (
  input  logic              clkMain,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              readEnable_i,
  input  logic [1:0]        regSel_i,
  input  logic [31:0]       dataSave_i,
  output logic [31:0]       dataLoad_o,
  output logic              int_o,
  input  logic              rxdReady_i,
  input  logic [DATA_W-1:0] rxdData_i,
  input  logic              txdBusy_i,
  output logic              txdStart_o,
  output logic [DATA_W-1:0] txdData_o
);

  import uart_fifo_pkg::*;

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] RX_LVL = CW'(RX_INT_LEVEL);

  logic              enable_q;
  logic              access;
  logic              rd_acc;
  logic              wr_acc;
  logic              rx_pop;
  logic              rx_full;
  logic              rx_empty;
  logic [DATA_W-1:0] rx_head;
  logic [CW-1:0]     rx_count;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic [CW-1:0]     tx_count;
  logic              rx_ovf;
  logic              tx_drop;
  logic [1:0]        ctrl;
  tx_state_e         tx_state;
  logic              unused_bits;

  assign unused_bits = ^dataSave_i[31:DATA_W];

  always_ff @(posedge clkMain) begin
    if (rst) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable_i;
    end
  end

  assign access  = enable_i & ~enable_q;
  assign rd_acc  = access & readEnable_i;
  assign wr_acc  = access & ~readEnable_i;
  assign rx_pop  = rd_acc & (regSel_i == REG_DATA);
  assign tx_push = wr_acc & (regSel_i == REG_DATA);
  assign tx_pop  = (tx_state == TX_START);

  sync_fifo #(.W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clkMain   (clkMain),
    .rst       (rst),
    .push      (rxdReady_i),
    .push_data (rxdData_i),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  sync_fifo #(.W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clkMain   (clkMain),
    .rst       (rst),
    .push      (tx_push),
    .push_data (dataSave_i[DATA_W-1:0]),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // A new overflow/drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clkMain) begin
    if (rst) begin
      rx_ovf  <= 1'b0;
      tx_drop <= 1'b0;
      ctrl    <= 2'b01;
    end else begin
      if (rxdReady_i & rx_full & ~rx_pop) begin
        rx_ovf <= 1'b1;
      end else if (wr_acc & (regSel_i == REG_STATUS) & dataSave_i[ST_RX_OVF]) begin
        rx_ovf <= 1'b0;
      end
      if (tx_push & tx_full & ~tx_pop) begin
        tx_drop <= 1'b1;
      end else if (wr_acc & (regSel_i == REG_STATUS) & dataSave_i[ST_TX_DROP]) begin
        tx_drop <= 1'b0;
      end
      if (wr_acc & (regSel_i == REG_CTRL)) begin
        ctrl <= dataSave_i[1:0];
      end
    end
  end

  always_ff @(posedge clkMain) begin
    if (rst) begin
      tx_state <= TX_IDLE;
    end else begin
      case (tx_state)
        TX_IDLE:  if (!tx_empty && !txdBusy_i) tx_state <= TX_START;
        TX_START: tx_state <= TX_GUARD;
        default:  tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txdStart_o = (tx_state == TX_START);
  assign txdData_o  = txdStart_o ? tx_head : '0;

  always_ff @(posedge clkMain) begin
    if (rst) begin
      int_o <= 1'b0;
    end else begin
      int_o <= (ctrl[0] & (rx_count >= RX_LVL)) | (ctrl[1] & tx_empty);
    end
  end

  always_comb begin
    dataLoad_o = '0;
    case (regSel_i)
      REG_DATA: begin
        if (!rx_empty) begin
          dataLoad_o = 32'(rx_head);
        end
      end
      REG_STATUS: begin
        dataLoad_o[ST_TX_NFULL]  = ~tx_full;
        dataLoad_o[ST_RX_NEMPTY] = ~rx_empty;
        dataLoad_o[ST_RX_OVF]    = rx_ovf;
        dataLoad_o[ST_TX_EMPTY]  = tx_empty;
        dataLoad_o[ST_TX_DROP]   = tx_drop;
        dataLoad_o[15:8]         = 8'(rx_count);
        dataLoad_o[23:16]        = 8'(tx_count);
      end
      REG_CTRL: dataLoad_o[1:0] = ctrl;
      default:  dataLoad_o = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - self-checking bench with a queue-based reference model
module tb_uart_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DL    = 4;
  localparam int LVL   = 1;
  localparam int DEPTH = 1 << DL;

  logic          clkMain = 1'b0;
  logic          rst = 1'b1;
  logic          enable_i = 1'b0;
  logic          readEnable_i = 1'b0;
  logic [1:0]    regSel_i = 2'd0;
  logic [31:0]   dataSave_i = 32'd0;
  logic          rxdReady_i = 1'b0;
  logic [DW-1:0] rxdData_i = '0;
  logic          txdBusy_i = 1'b0;
  logic [31:0]   dataLoad_o;
  logic          int_o;
  logic          txdStart_o;
  logic [DW-1:0] txdData_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_fifo_ctrl #(.DATA_W(DW), .DEPTH_LOG2(DL), .RX_INT_LEVEL(LVL)) dut (
    .clkMain      (clkMain),
    .rst          (rst),
    .enable_i     (enable_i),
    .readEnable_i (readEnable_i),
    .regSel_i     (regSel_i),
    .dataSave_i   (dataSave_i),
    .dataLoad_o   (dataLoad_o),
    .int_o        (int_o),
    .rxdReady_i   (rxdReady_i),
    .rxdData_i    (rxdData_i),
    .txdBusy_i    (txdBusy_i),
    .txdStart_o   (txdStart_o),
    .txdData_o    (txdData_o)
  );

  always #5 clkMain = ~clkMain;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queues for the FIFOs, launch times as cycle numbers.
  logic [DW-1:0] rxq[$];
  logic [DW-1:0] txq[$];
  bit       m_ovf, m_drop, m_int, m_en_prev, synced;
  bit [1:0] m_ctrl;
  int       cyc = 0;
  int       last_start = -10;

  function automatic logic [31:0] model_load();
    logic [31:0] v;
    v = 32'd0;
    case (regSel_i)
      2'd0: if (rxq.size() > 0) v = {24'd0, rxq[0]};
      2'd1: begin
        v[0] = (txq.size() < DEPTH);
        v[1] = (rxq.size() > 0);
        v[2] = m_ovf;
        v[3] = (txq.size() == 0);
        v[4] = m_drop;
        v[15:8]  = 8'(rxq.size());
        v[23:16] = 8'(txq.size());
      end
      2'd2: v[1:0] = m_ctrl;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    bit access, launch, starting;
    if (rst) begin
      rxq.delete();
      txq.delete();
      m_ovf = 0; m_drop = 0; m_int = 0; m_en_prev = 0;
      m_ctrl = 2'b01;
      last_start = cyc - 10;
      synced = 1;
      return;
    end
    access    = enable_i && !m_en_prev;
    m_en_prev = enable_i;
    starting  = (cyc == last_start);
    launch    = (cyc - last_start >= 2) && (txq.size() > 0) && !txdBusy_i;
    m_int     = (m_ctrl[0] && rxq.size() >= LVL) || (m_ctrl[1] && txq.size() == 0);
    if (access && readEnable_i && regSel_i == 2'd0 && rxq.size() > 0) void'(rxq.pop_front());
    if (access && !readEnable_i && regSel_i == 2'd1) begin
      if (dataSave_i[2]) m_ovf = 0;
      if (dataSave_i[4]) m_drop = 0;
    end
    if (rxdReady_i) begin
      if (rxq.size() < DEPTH) rxq.push_back(rxdData_i);
      else m_ovf = 1;
    end
    if (access && !readEnable_i && regSel_i == 2'd2) m_ctrl = dataSave_i[1:0];
    if (starting) void'(txq.pop_front());
    if (access && !readEnable_i && regSel_i == 2'd0) begin
      if (txq.size() < DEPTH) txq.push_back(dataSave_i[DW-1:0]);
      else m_drop = 1;
    end
    if (launch) last_start = cyc + 1;
  endtask

  always @(negedge clkMain) begin
    if (synced) begin
      check("dataLoad_o", dataLoad_o, model_load());
      check("int_o", 32'(int_o), 32'(m_int));
      check("txdStart_o", 32'(txdStart_o), 32'(cyc == last_start));
      check("txdData_o", 32'(txdData_o), (cyc == last_start) ? 32'(txq[0]) : 32'd0);
    end
    model_step();
    cyc++;
  end

  task automatic drive(input bit en, input bit re, input bit [1:0] sel, input bit [31:0] din,
                       input bit rxv, input bit [7:0] rxd);
    @(posedge clkMain);
    #1;
    enable_i = en; readEnable_i = re; regSel_i = sel; dataSave_i = din;
    rxdReady_i = rxv; rxdData_i = rxd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 2'd0, 32'd0, 0, 8'd0);
  endtask

  task automatic rd(input bit [1:0] sel, output logic [31:0] v);
    drive(1, 1, sel, 32'd0, 0, 8'd0);
    #2 v = dataLoad_o;
    idle(1);
  endtask

  task automatic wr(input bit [1:0] sel, input bit [31:0] din);
    drive(1, 0, sel, din, 0, 8'd0);
    idle(1);
  endtask

  task automatic wait_start(output bit seen);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive(0, 0, 2'd0, 32'd0, 0, 8'd0);
      #2 if (txdStart_o === 1'b1) seen = 1;
    end
  endtask

  initial begin
    logic [31:0] v;
    bit seen;
    int starts;

    rst = 1; idle(3); rst = 0;
    rd(2'd1, v);
    check("reset_status", v, 32'h0000_0009);
    check("reset_int", 32'(int_o), 32'd0);

    drive(0, 0, 2'd0, 32'd0, 1, 8'h41);
    drive(0, 0, 2'd0, 32'd0, 1, 8'h42);
    drive(0, 0, 2'd0, 32'd0, 1, 8'h43);
    idle(2);
    check("rx_level_int", 32'(int_o), 32'd1);
    rd(2'd1, v);
    check("rx_count3", 32'(v[15:8]), 32'd3);
    rd(2'd0, v); check("rx_read0", v, 32'h41);
    rd(2'd0, v); check("rx_read1", v, 32'h42);
    rd(2'd0, v); check("rx_read2", v, 32'h43);
    rd(2'd0, v); check("rx_read_empty", v, 32'h0);
    idle(1);
    check("rx_int_fall", 32'(int_o), 32'd0);

    for (int i = 0; i < 17; i++) drive(0, 0, 2'd0, 32'd0, 1, 8'($urandom));
    idle(1);
    rd(2'd1, v); check("rx_overflow_status", v, 32'h0000_100F);
    wr(2'd1, 32'h4);
    rd(2'd1, v); check("rx_ovf_cleared", v, 32'h0000_100B);
    drive(1, 1, 2'd0, 32'd0, 1, 8'h77);
    idle(1);
    rd(2'd1, v); check("full_push_pop", v, 32'h0000_100B);
    for (int i = 0; i < 16; i++) rd(2'd0, v);

    txdBusy_i = 0;
    drive(1, 0, 2'd0, 32'h55, 0, 8'd0);
    wait_start(seen);
    check("launch55_seen", 32'(seen), 32'd1);
    check("launch55_data", 32'(txdData_o), 32'h55);
    drive(1, 0, 2'd0, 32'hAA, 0, 8'd0);
    txdBusy_i = 1;
    starts = 0;
    repeat (20) begin
      drive(0, 0, 2'd0, 32'd0, 0, 8'd0);
      #2 if (txdStart_o === 1'b1) starts++;
    end
    check("busy_blocks_launch", 32'(starts), 32'd0);
    txdBusy_i = 0;
    wait_start(seen);
    check("launchAA_seen", 32'(seen), 32'd1);
    check("launchAA_data", 32'(txdData_o), 32'hAA);
    wr(2'd2, 32'h2);
    idle(3);
    check("tx_empty_int", 32'(int_o), 32'd1);

    drive(0, 0, 2'd0, 32'd0, 1, 8'h11);
    drive(0, 0, 2'd0, 32'd0, 1, 8'h22);
    idle(1);
    repeat (5) drive(1, 1, 2'd0, 32'd0, 0, 8'd0);
    idle(1);
    rd(2'd1, v); check("held_enable_one_pop", v, 32'h0000_010B);
    rd(2'd0, v); check("held_enable_remaining", v, 32'h22);

    txdBusy_i = 1;
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h10 + i);
    txdBusy_i = 0;
    wait_start(seen);
    check("rst_start_seen", 32'(seen), 32'd1);
    rst = 1;
    drive(1, 1, 2'd1, 32'd0, 0, 8'd0);
    rst = 0;
    #2;
    check("rst_suppress_start", 32'(txdStart_o), 32'd0);
    check("rst_flush_status", dataLoad_o, 32'h0000_0009);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom, ($urandom_range(0, 2) == 0), 8'($urandom));
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) txdBusy_i = ~txdBusy_i;
    end
    rst = 0;
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
